// File: rtl/icache_if.sv
// Fetch-unit and memory-controller signal bundle for the instruction cache.
// The cache takes the slave side; the fetch unit and memory controller drive the master side.
interface icache_if;
  logic        IF_addr_sgn;
  logic [31:0] IF_addr;
  logic        pc_change;
  logic        IF_ins_sgn;
  logic [31:0] IF_ins;
  logic        MC_req;
  logic [31:0] MC_addr;
  logic        MC_done;
  logic [31:0] MC_data;

  modport slave (
    input  IF_addr_sgn, IF_addr, pc_change, MC_done, MC_data,
    output IF_ins_sgn, IF_ins, MC_req, MC_addr
  );

  modport master (
    output IF_addr_sgn, IF_addr, pc_change, MC_done, MC_data,
    input  IF_ins_sgn, IF_ins, MC_req, MC_addr
  );
endinterface

// File: rtl/icache.sv
// Direct-mapped, one-word-per-line instruction cache with a single outstanding miss.
// Aborted misses still fill the line but deliver nothing to the fetch unit.
module icache #(
  parameter int unsigned INDEX_BITS = 8
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    rdy,
  icache_if.slave bus
);
  localparam int unsigned LINES    = 2 ** INDEX_BITS;
  localparam int unsigned TAG_BITS = 30 - INDEX_BITS;

  typedef enum logic [1:0] {IDLE, RESP, MISS} state_t;

  state_t              state_q, state_d;
  logic [LINES-1:0]    valid_q;
  logic [TAG_BITS-1:0] tag_q  [LINES];
  logic [31:0]         data_q [LINES];

  logic        ins_sgn_q, ins_sgn_d;
  logic [31:0] ins_q, ins_d;
  logic        req_q, req_d;
  logic [31:0] maddr_q, maddr_d;
  logic        abort_q, abort_d;
  logic        fill;

  logic [INDEX_BITS-1:0] req_idx, fill_idx;
  logic [TAG_BITS-1:0]   req_tag, fill_tag;
  logic                  hit;
  logic                  unused_bits;

  assign req_idx     = bus.IF_addr[INDEX_BITS+1:2];
  assign req_tag     = bus.IF_addr[31:INDEX_BITS+2];
  assign fill_idx    = maddr_q[INDEX_BITS+1:2];
  assign fill_tag    = maddr_q[31:INDEX_BITS+2];
  assign hit         = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
  assign unused_bits = ^bus.IF_addr[1:0];

  // Next-state and next-output logic
  always_comb begin
    state_d   = state_q;
    ins_sgn_d = 1'b0;
    ins_d     = ins_q;
    req_d     = req_q;
    maddr_d   = maddr_q;
    abort_d   = abort_q;
    fill      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.IF_addr_sgn && !bus.pc_change) begin
          if (hit) begin
            ins_sgn_d = 1'b1;
            ins_d     = data_q[req_idx];
            state_d   = RESP;
          end else begin
            req_d   = 1'b1;
            maddr_d = {bus.IF_addr[31:2], 2'b00};
            abort_d = 1'b0;
            state_d = MISS;
          end
        end
      end
      // Fetch unit still shows the old PC here, so any request is stale.
      RESP: state_d = IDLE;
      MISS: begin
        if (bus.MC_done) begin
          fill    = 1'b1;
          req_d   = 1'b0;
          abort_d = 1'b0;
          if (abort_q || bus.pc_change) begin
            state_d = IDLE;
          end else begin
            ins_sgn_d = 1'b1;
            ins_d     = bus.MC_data;
            state_d   = RESP;
          end
        end else if (bus.pc_change) begin
          abort_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, control and valid bits; rdy low freezes everything
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      valid_q   <= '0;
      ins_sgn_q <= 1'b0;
      ins_q     <= '0;
      req_q     <= 1'b0;
      maddr_q   <= '0;
      abort_q   <= 1'b0;
    end else if (rdy) begin
      state_q   <= state_d;
      ins_sgn_q <= ins_sgn_d;
      ins_q     <= ins_d;
      req_q     <= req_d;
      maddr_q   <= maddr_d;
      abort_q   <= abort_d;
      if (fill) valid_q[fill_idx] <= 1'b1;
    end
  end

  // Tag and data storage carry no reset; valid bits gate their use
  always_ff @(posedge clk) begin
    if (!rst && rdy && fill) begin
      tag_q[fill_idx]  <= fill_tag;
      data_q[fill_idx] <= bus.MC_data;
    end
  end

  assign bus.IF_ins_sgn = ins_sgn_q;
  assign bus.IF_ins     = ins_q;
  assign bus.MC_req     = req_q;
  assign bus.MC_addr    = maddr_q;
endmodule
